// File: rtl/si_tag_serializer.sv
// rtl/si_tag_serializer.sv - multi-lane tag beat to single-tag stream serializer
//
// Purpose:
//   Accepts beats of up to NUMBER_OF_WORDS parsed tags (each lane flagged by a
//   keep bit) and emits the kept tags one per cycle in ascending lane order on
//   a single-tag stream with full backpressure. Sustains one tag per cycle
//   across beat boundaries when the downstream is always ready.
//
// Optional feature (macro SI_TAG_SERIALIZER_ORDER_CHECK_EN):
//   When defined, every transferred tag time is compared (unsigned) with the
//   previously transferred one; a strict decrease sets the sticky order_error
//   and bumps the saturating order_error_count. When undefined both outputs
//   are tied to 0 and no compare logic exists.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   s_axis_tvalid      input beat valid
//   s_axis_tready      input beat accepted when high together with tvalid
//   s_axis_tagtime     NUMBER_OF_WORDS x TIME_WIDTH tag times, lane i at [i*TIME_WIDTH +: TIME_WIDTH]
//   s_axis_channel     NUMBER_OF_WORDS x 6 signed channels, lane i at [i*6 +: 6]
//   s_axis_tkeep       lane i carries a valid tag
//   m_axis_tvalid      output tag valid
//   m_axis_tready      downstream ready
//   m_axis_tagtime     output tag time
//   m_axis_channel     output signed channel
//   m_axis_tlast       tag is the last kept lane of its input beat
//   order_error        sticky out-of-order flag (optional feature)
//   order_error_count  saturating out-of-order count (optional feature)

module si_tag_serializer #(
  parameter int NUMBER_OF_WORDS = 4,
  parameter int TIME_WIDTH      = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [NUMBER_OF_WORDS*TIME_WIDTH-1:0] s_axis_tagtime,
  input  logic [NUMBER_OF_WORDS*6-1:0]          s_axis_channel,
  input  logic [NUMBER_OF_WORDS-1:0]            s_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [TIME_WIDTH-1:0]                 m_axis_tagtime,
  output logic signed [5:0]                     m_axis_channel,
  output logic                                  m_axis_tlast,
  output logic                                  order_error,
  output logic [15:0]                           order_error_count
);

  localparam logic [NUMBER_OF_WORDS-1:0] KEEP_ONE = NUMBER_OF_WORDS'(1);

  // Hold register: the whole accepted beat plus the lanes still to emit.
  logic [NUMBER_OF_WORDS*TIME_WIDTH-1:0] hold_time_q, hold_time_d;
  logic [NUMBER_OF_WORDS*6-1:0]          hold_chan_q, hold_chan_d;
  logic [NUMBER_OF_WORDS-1:0]            hold_keep_q, hold_keep_d;

  // Output register: one tag.
  logic                  m_tvalid_q, m_tvalid_d;
  logic [TIME_WIDTH-1:0] m_time_q, m_time_d;
  logic [5:0]            m_chan_q, m_chan_d;
  logic                  m_last_q, m_last_d;

  logic                       out_adv;
  logic                       keep_onehot;
  logic                       s_ready;
  logic [NUMBER_OF_WORDS-1:0] sel_mask;
  logic [TIME_WIDTH-1:0]      sel_time;
  logic [5:0]                 sel_chan;

  always_comb begin
    out_adv     = !m_tvalid_q || m_axis_tready;
    // Exactly one lane left: emitting it this cycle frees the hold register.
    keep_onehot = (hold_keep_q != '0) && ((hold_keep_q & (hold_keep_q - KEEP_ONE)) == '0);
    s_ready     = (hold_keep_q == '0) || (keep_onehot && out_adv);

    // Isolate the lowest remaining lane, then mux its data out of the beat.
    sel_mask = hold_keep_q & (~hold_keep_q + KEEP_ONE);
    sel_time = '0;
    sel_chan = '0;
    for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
      if (sel_mask[i]) begin
        sel_time = hold_time_q[i*TIME_WIDTH +: TIME_WIDTH];
        sel_chan = hold_chan_q[i*6 +: 6];
      end
    end
  end

  always_comb begin
    hold_time_d = hold_time_q;
    hold_chan_d = hold_chan_q;
    hold_keep_d = hold_keep_q;
    m_tvalid_d  = m_tvalid_q;
    m_time_d    = m_time_q;
    m_chan_d    = m_chan_q;
    m_last_d    = m_last_q;

    if (out_adv) begin
      if (hold_keep_q != '0) begin
        m_tvalid_d  = 1'b1;
        m_time_d    = sel_time;
        m_chan_d    = sel_chan;
        m_last_d    = keep_onehot;
        hold_keep_d = hold_keep_q & ~sel_mask;
      end else begin
        m_tvalid_d = 1'b0;
      end
    end

    // Placed after the selection so a new beat overrides the cleared mask
    // when the last lane leaves in the same cycle.
    if (s_axis_tvalid && s_ready) begin
      hold_time_d = s_axis_tagtime;
      hold_chan_d = s_axis_channel;
      hold_keep_d = s_axis_tkeep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_time_q <= '0;
      hold_chan_q <= '0;
      hold_keep_q <= '0;
      m_tvalid_q  <= 1'b0;
      m_time_q    <= '0;
      m_chan_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      hold_time_q <= hold_time_d;
      hold_chan_q <= hold_chan_d;
      hold_keep_q <= hold_keep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_time_q    <= m_time_d;
      m_chan_q    <= m_chan_d;
      m_last_q    <= m_last_d;
    end
  end

  assign s_axis_tready  = s_ready;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tagtime = m_time_q;
  assign m_axis_channel = m_chan_q;
  assign m_axis_tlast   = m_last_q;

`ifdef SI_TAG_SERIALIZER_ORDER_CHECK_EN
  logic [TIME_WIDTH-1:0] prev_time_q, prev_time_d;
  logic                  order_error_q, order_error_d;
  logic [15:0]           order_count_q, order_count_d;

  always_comb begin
    prev_time_d   = prev_time_q;
    order_error_d = order_error_q;
    order_count_d = order_count_q;
    if (m_tvalid_q && m_axis_tready) begin
      prev_time_d = m_time_q;
      // Equal times are legal; only a strict decrease is an error.
      if (m_time_q < prev_time_q) begin
        order_error_d = 1'b1;
        if (order_count_q != 16'hFFFF) begin
          order_count_d = order_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_time_q   <= '0;
      order_error_q <= 1'b0;
      order_count_q <= '0;
    end else begin
      prev_time_q   <= prev_time_d;
      order_error_q <= order_error_d;
      order_count_q <= order_count_d;
    end
  end

  assign order_error       = order_error_q;
  assign order_error_count = order_count_q;
`else
  assign order_error       = 1'b0;
  assign order_error_count = 16'd0;
`endif

endmodule

// File: tb/tb_si_tag_serializer.sv
// tb/tb_si_tag_serializer.sv - self-checking bench for si_tag_serializer
module tb_si_tag_serializer;

  localparam int N  = 4;
  localparam int TW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_tvalid;
  logic            s_tready;
  logic [N*TW-1:0] s_tagtime;
  logic [N*6-1:0]  s_channel;
  logic [N-1:0]    s_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic [TW-1:0]   m_tagtime;
  logic signed [5:0] m_channel;
  logic            m_tlast;
  logic            order_error;
  logic [15:0]     order_error_count;

  always #5 clk = ~clk;

  si_tag_serializer #(.NUMBER_OF_WORDS(N), .TIME_WIDTH(TW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tagtime    (s_tagtime),
    .s_axis_channel    (s_channel),
    .s_axis_tkeep      (s_tkeep),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tagtime    (m_tagtime),
    .m_axis_channel    (m_channel),
    .m_axis_tlast      (m_tlast),
    .order_error       (order_error),
    .order_error_count (order_error_count)
  );

  typedef struct {
    logic [TW-1:0] t;
    logic [5:0]    c;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Drive one beat (called at posedge+1), push its expected tags, and wait
  // for the handshake. tvalid is left high so beats can follow back-to-back.
  task automatic drive_beat(input logic [3:0] keep, input logic [3:0][63:0] t,
                            input logic [3:0][5:0] c, output int waited);
    int hi;
    hi = -1;
    waited = 0;
    for (int i = 0; i < N; i++) if (keep[i]) hi = i;
    for (int i = 0; i < N; i++) if (keep[i]) exp_q.push_back('{t[i], c[i], (i == hi)});
    s_tvalid  = 1'b1;
    s_tkeep   = keep;
    s_tagtime = t;
    s_channel = c;
    @(negedge clk);
    while (!s_tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!s_tready) begin
      failures++;
      $display("FAIL beat_accept_timeout: s_axis_tready=%0b required=1", s_tready);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: pop on each transfer, check the head is held while stalled.
  task automatic collect(input int n, input int budget, output int span);
    int got, waited, first, last;
    exp_t e;
    got = 0; waited = 0; first = 0; last = 0;
    while (got < n && waited < budget) begin
      @(negedge clk);
      waited++;
      if (m_tvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_tag: time=%0d ch=%0d required=no output", m_tagtime, m_channel);
        end else if (m_tready) begin
          e = exp_q.pop_front();
          if ({m_tagtime, m_channel, m_tlast} !== {e.t, e.c, e.l}) begin
            failures++;
            $display("FAIL tag_data: got (%0d,%0d,last%0b) required (%0d,%0d,last%0b)",
                     m_tagtime, m_channel, m_tlast, e.t, $signed(e.c), e.l);
          end
          if (got == 0) first = waited;
          last = waited;
          got++;
        end else begin
          e = exp_q[0];
          if ({m_tagtime, m_channel, m_tlast} !== {e.t, e.c, e.l}) begin
            failures++;
            $display("FAIL tag_hold: got (%0d,%0d,last%0b) required (%0d,%0d,last%0b)",
                     m_tagtime, m_channel, m_tlast, e.t, $signed(e.c), e.l);
          end
        end
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL collect_count: got %0d tags required %0d", got, n);
    end
    span = last - first;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tkeep = '0; s_tagtime = '0; s_channel = '0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tagtime, m_channel, m_tlast} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tvalid=%0b time=%0d ch=%0d last=%0b required all 0",
               m_tvalid, m_tagtime, m_channel, m_tlast);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s_tready: got %0b required 1", s_tready);
    end
    checks++;
    if ({order_error, order_error_count} !== 17'd0) begin
      failures++;
      $display("FAIL reset_order: err=%0b count=%0d required 0", order_error, order_error_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    exp_t e;
    @(posedge clk); #1;
    t = '0; c = '0;
    t[0] = 100; t[1] = 200; t[3] = 400;
    c[0] = 6'sd1; c[1] = -6'sd3; c[3] = 6'sd18;
    exp_q.push_back('{64'd100, 6'sd1, 1'b0});
    exp_q.push_back('{64'd200, -6'sd3, 1'b0});
    exp_q.push_back('{64'd400, 6'sd18, 1'b1});
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tkeep = 4'b1011; s_tagtime = t; s_channel = c;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL single_accept: s_tready=%0b required 1", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== (k >= 3)) begin
        failures++;
        $display("FAIL single_s_tready n+%0d: got %0b required %0b", k, s_tready, (k >= 3));
      end
      checks++;
      if (m_tvalid !== (k >= 2 && k <= 4)) begin
        failures++;
        $display("FAIL single_m_tvalid n+%0d: got %0b required %0b", k, m_tvalid, (k >= 2 && k <= 4));
      end
      if (m_tvalid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tagtime, m_channel, m_tlast} !== {e.t, e.c, e.l}) begin
          failures++;
          $display("FAIL single_tag n+%0d: got (%0d,%0d,last%0b) required (%0d,%0d,last%0b)",
                   k, m_tagtime, m_channel, m_tlast, e.t, $signed(e.c), e.l);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    int w, span;
    @(posedge clk); #1;
    m_tready = 1'b1;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          t = '0; c = '0;
          t[2] = 64'(1000 + b);
          c[2] = 6'(b + 1);
          drive_beat(4'b0100, t, c, w);
          checks++;
          if (w != 0) begin
            failures++;
            $display("FAIL b2b_s_tready beat %0d: stalled %0d cycles required 0", b, w);
          end
        end
        s_tvalid = 1'b0;
      end
      collect(8, 60, span);
    join
    checks++;
    if (span != 7) begin
      failures++;
      $display("FAIL b2b_span: got %0d cycles required 7", span);
    end
  endtask

  task automatic test_tready_toggle();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    int w, span;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      t[i] = 64'(2000 + 10 * i);
      c[i] = 6'(-(i + 2));
    end
    fork
      begin
        drive_beat(4'b1111, t, c, w);
        s_tvalid = 1'b0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          m_tready = (k % 2 == 0);
          @(posedge clk); #1;
        end
      end
      collect(4, 40, span);
    join
    m_tready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL toggle_leftover: %0d tags missing required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_keep();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    int w, span;
    @(posedge clk); #1;
    m_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin t[i] = 64'(3000 + i); c[i] = 6'(i + 5); end
        drive_beat(4'b1111, t, c, w);
        drive_beat(4'b0000, t, c, w);
        for (int i = 0; i < 4; i++) begin t[i] = 64'(3100 + i); c[i] = 6'(i + 9); end
        drive_beat(4'b1111, t, c, w);
        s_tvalid = 1'b0;
      end
      collect(8, 60, span);
    join
    checks++;
    if (span > 8) begin
      failures++;
      $display("FAIL zero_keep_span: got %0d cycles required <= 8", span);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL zero_keep_extra: m_tvalid=%0b required 0", m_tvalid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    int w, span;
    @(posedge clk); #1;
    m_tready = 1'b0;
    t = '0; c = '0;
    t[0] = 11; t[1] = 12; t[2] = 13;
    c[0] = 6'sd1; c[1] = 6'sd2; c[2] = 6'sd3;
    drive_beat(4'b0111, t, c, w);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_tvalid: got %0b required 0", m_tvalid);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_s_tready: got %0b required 1", s_tready);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    t = '0; c = '0;
    t[0] = 7; c[0] = 6'sd5;
    drive_beat(4'b0001, t, c, w);
    s_tvalid = 1'b0;
    collect(1, 20, span);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_extra: m_tvalid=%0b required 0", m_tvalid);
      end
    end
  endtask

  task automatic test_order_check();
    logic [3:0][63:0] t;
    logic [3:0][5:0]  c;
    logic [63:0] tv [3];
    int w, span;
    tv[0] = 500; tv[1] = 500; tv[2] = 499;
    @(posedge clk); #1;
    m_tready = 1'b1;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          t = '0; c = '0;
          t[0] = tv[b]; c[0] = 6'sd4;
          drive_beat(4'b0001, t, c, w);
        end
        s_tvalid = 1'b0;
      end
      collect(3, 30, span);
    join
    @(posedge clk);
    @(negedge clk);
`ifdef SI_TAG_SERIALIZER_ORDER_CHECK_EN
    checks++;
    if (order_error !== 1'b1 || order_error_count !== 16'd1) begin
      failures++;
      $display("FAIL order_first: err=%0b count=%0d required err=1 count=1", order_error, order_error_count);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int b = 0; b < 16385; b++) begin
          for (int i = 0; i < 4; i++) begin
            t[i] = 64'(1000000 - (4 * b + i));
            c[i] = 6'sd1;
          end
          drive_beat(4'b1111, t, c, w);
        end
        s_tvalid = 1'b0;
      end
      collect(65540, 70000, span);
    join
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (order_error !== 1'b1 || order_error_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL order_saturate: err=%0b count=%0d required err=1 count=65535", order_error, order_error_count);
    end
`else
    checks++;
    if (order_error !== 1'b0 || order_error_count !== 16'd0) begin
      failures++;
      $display("FAIL order_disabled: err=%0b count=%0d required 0", order_error, order_error_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tready_toggle();
    test_zero_keep();
    test_reset_midstream();
    test_order_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
